// File: rtl/bcd_conv_scheduler_pkg.sv
// Shared state encoding, data widths and counter sizing for the BCD converter scheduler.
package bcd_conv_scheduler_pkg;

    localparam int BIN_W    = 12;
    localparam int BCD_W    = 16;
    localparam int ERR_CH_W = 3;

    typedef enum logic [2:0] {
        S_DRAIN,
        S_IDLE,
        S_ARB,
        S_LAUNCH,
        S_WAIT
    } state_e;

    function automatic int cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

    function automatic int idx_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/bcd_conv_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above the pointer, wrapping to 0.
module bcd_conv_scheduler_rr_arbiter
    import bcd_conv_scheduler_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [CH_W-1:0]   grant_o,
    output logic              valid_o
);

    always_comb begin
        logic [CH_W-1:0] idx;
        grant_o = '0;
        valid_o = 1'b0;
        idx     = '0;
        // Walk from farthest to nearest so the last hit is the highest-priority one.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = CH_W'((int'(ptr_i) + i) % NUM_CH);
            if (req_i[idx]) begin
                grant_o = idx;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Shares one binary-to-BCD converter between NUM_CH requesters with round-robin arbitration.
//   state  | meaning
//   DRAIN  | wait out a possibly running conversion (after reset or timeout)
//   IDLE   | no conversion in flight, waiting for any request
//   ARB    | pick a channel, capture its operand, pulse ack
//   LAUNCH | single-cycle conv_en strobe
//   WAIT   | wait for conv_rdy or timeout
module bcd_conv_scheduler
    import bcd_conv_scheduler_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 128
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_CH-1:0]         req_i,
    input  logic [NUM_CH*BIN_W-1:0]   bin_in_i,
    output logic [NUM_CH-1:0]         ack_o,
    output logic [NUM_CH-1:0]         res_valid_o,
    output logic [NUM_CH*BCD_W-1:0]   bcd_out_o,
    output logic                      err_o,
    output logic [ERR_CH_W-1:0]       err_ch_o,
    output logic                      busy_o,
    output logic                      conv_en_o,
    output logic [BIN_W-1:0]          conv_bin_o,
    input  logic [BCD_W-1:0]          conv_bcd_i,
    input  logic                      conv_rdy_i
);

    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam int CH_W  = idx_width(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e                    state_q;
    logic [CH_W-1:0]           ptr_q;
    logic [CH_W-1:0]           gch_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [NUM_CH-1:0]         ack_q;
    logic [NUM_CH-1:0]         res_valid_q;
    logic [NUM_CH*BCD_W-1:0]   bcd_q;
    logic                      err_q;
    logic [ERR_CH_W-1:0]       err_ch_q;
    logic                      busy_q;
    logic                      conv_en_q;
    logic [BIN_W-1:0]          conv_bin_q;

    logic [CH_W-1:0]           arb_grant;
    logic                      arb_valid;

    bcd_conv_scheduler_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_arbiter (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .valid_o (arb_valid)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_DRAIN;
            ptr_q       <= '0;
            gch_q       <= '0;
            cnt_q       <= '0;
            ack_q       <= '0;
            res_valid_q <= '0;
            bcd_q       <= '0;
            err_q       <= 1'b0;
            err_ch_q    <= '0;
            busy_q      <= 1'b0;
            conv_en_q   <= 1'b0;
            conv_bin_q  <= '0;
        end else begin
            ack_q       <= '0;
            res_valid_q <= '0;
            err_q       <= 1'b0;
            conv_en_q   <= 1'b0;
            case (state_q)
                S_DRAIN: begin
                    // The converter has no reset; a late conv_rdy only ends the drain.
                    if (conv_rdy_i || cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (|req_i) begin
                        busy_q  <= 1'b1;
                        state_q <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (arb_valid) begin
                        gch_q            <= arb_grant;
                        ptr_q            <= (arb_grant == CH_W'(NUM_CH - 1)) ? '0 : arb_grant + 1'b1;
                        conv_bin_q       <= bin_in_i[arb_grant*BIN_W +: BIN_W];
                        ack_q[arb_grant] <= 1'b1;
                        conv_en_q        <= 1'b1;
                        state_q          <= S_LAUNCH;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_LAUNCH: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (conv_rdy_i) begin
                        bcd_q[gch_q*BCD_W +: BCD_W] <= conv_bcd_i;
                        res_valid_q[gch_q]          <= 1'b1;
                        cnt_q                       <= '0;
                        busy_q                      <= 1'b0;
                        state_q                     <= S_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        err_q    <= 1'b1;
                        err_ch_q <= ERR_CH_W'(gch_q);
                        cnt_q    <= '0;
                        state_q  <= S_DRAIN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= S_DRAIN;
                end
            endcase
        end
    end

    assign ack_o       = ack_q;
    assign res_valid_o = res_valid_q;
    assign bcd_out_o   = bcd_q;
    assign err_o       = err_q;
    assign err_ch_o    = err_ch_q;
    assign busy_o      = busy_q;
    assign conv_en_o   = conv_en_q;
    assign conv_bin_o  = conv_bin_q;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Scoreboard bench for bcd_conv_scheduler with a behavioural converter and round-robin model.
module tb_bcd_conv_scheduler;

    localparam int NUM_CH  = 4;
    localparam int TIMEOUT = 128;
    localparam int NOM_LAT = 62;
    localparam int BUDGET  = 2000;
    localparam int EV_ACK  = 0;
    localparam int EV_RES  = 1;
    localparam int EV_ERR  = 2;

    typedef struct {
        int          kind;
        int          ch;
        logic [15:0] val;
    } exp_t;

    logic                   clk_i = 1'b0;
    logic                   rst_i = 1'b1;
    logic [NUM_CH-1:0]      req_i = '0;
    logic [NUM_CH*12-1:0]   bin_in_i = '0;
    logic [NUM_CH-1:0]      ack_o;
    logic [NUM_CH-1:0]      res_valid_o;
    logic [NUM_CH*16-1:0]   bcd_out_o;
    logic                   err_o;
    logic [2:0]             err_ch_o;
    logic                   busy_o;
    logic                   conv_en_o;
    logic [11:0]            conv_bin_o;
    logic [15:0]            conv_bcd_i = '0;
    logic                   conv_rdy_i = 1'b0;

    bcd_conv_scheduler #(
        .NUM_CH  (NUM_CH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .bin_in_i    (bin_in_i),
        .ack_o       (ack_o),
        .res_valid_o (res_valid_o),
        .bcd_out_o   (bcd_out_o),
        .err_o       (err_o),
        .err_ch_o    (err_ch_o),
        .busy_o      (busy_o),
        .conv_en_o   (conv_en_o),
        .conv_bin_o  (conv_bin_o),
        .conv_bcd_i  (conv_bcd_i),
        .conv_rdy_i  (conv_rdy_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    exp_t        exp_q[$];
    logic [15:0] exp_bcd [NUM_CH];
    logic [11:0] vals [NUM_CH];
    int          rr_ptr = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          en_count = 0;
    int          en_cyc = 0;
    int          err_cyc = 0;
    int          last_ack_cyc = 0;
    int          d0 = 0;
    int          mon_ch = 0;

    int          lat = NOM_LAT;
    bit          stall = 1'b0;
    bit          spur = 1'b0;
    bit          m_active = 1'b0;
    bit          prev_en = 1'b0;
    int          m_rem = 0;
    logic [11:0] m_bin = '0;

    task automatic chk(input bit ok, input string name, input string detail);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [NUM_CH*16-1:0] pack_bcd();
        logic [NUM_CH*16-1:0] p;
        p = '0;
        for (int k = 0; k < NUM_CH; k++) p[k*16 +: 16] = exp_bcd[k];
        return p;
    endfunction

    function automatic int low_idx(input logic [NUM_CH-1:0] v);
        int r;
        r = -1;
        for (int k = NUM_CH - 1; k >= 0; k--) if (v[k]) r = k;
        return r;
    endfunction

    function automatic int rr_pick(input logic [NUM_CH-1:0] mask);
        int k;
        for (int i = 0; i < NUM_CH; i++) begin
            k = (rr_ptr + i) % NUM_CH;
            if (mask[k]) return k;
        end
        return -1;
    endfunction

    task automatic push_exp(input int kind, input int ch, input logic [15:0] val);
        exp_t e;
        e.kind = kind;
        e.ch   = ch;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input int kind, input int ch, input bit onehot, input logic [15:0] val);
        exp_t e;
        string nm;
        if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_event",
                $sformatf("got kind %0d ch %0d, required no event", kind, ch));
            return;
        end
        e  = exp_q.pop_front();
        nm = (e.kind == EV_ACK) ? "ack_grant" : (e.kind == EV_RES) ? "result" : "timeout_err";
        chk(onehot && e.kind == kind && e.ch == ch && (kind != EV_RES || e.val == val), nm,
            $sformatf("got kind %0d ch %0d val %h onehot %0d, required kind %0d ch %0d val %h",
                      kind, ch, val, onehot, e.kind, e.ch, e.val));
        if (e.kind == EV_RES) exp_bcd[e.ch] = e.val;
        if (kind != EV_ACK)
            chk(bcd_out_o == pack_bcd(), "bcd_hold",
                $sformatf("got %h, required %h", bcd_out_o, pack_bcd()));
    endtask

    // Monitor: every DUT event is matched against the head of the expectation queue.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (ack_o != '0)
                    sb_pop(EV_ACK, low_idx(ack_o), $countones(ack_o) == 1, 16'h0);
                if (res_valid_o != '0) begin
                    mon_ch = low_idx(res_valid_o);
                    sb_pop(EV_RES, mon_ch, $countones(res_valid_o) == 1, bcd_out_o[mon_ch*16 +: 16]);
                end
                if (err_o) begin
                    err_cyc = cyc;
                    sb_pop(EV_ERR, int'(err_ch_o), 1'b1, 16'h0);
                end
            end
        end
    end

    // Converter model: answers lat cycles after the strobe, can stall or fire spuriously.
    initial begin
        forever begin
            @(negedge clk_i);
            conv_rdy_i = 1'b0;
            if (spur) begin
                conv_rdy_i = 1'b1;
                conv_bcd_i = 16'hdead;
                spur       = 1'b0;
            end
            if (m_active) begin
                m_rem--;
                if (m_rem == 0) begin
                    conv_rdy_i = 1'b1;
                    conv_bcd_i = ref_bcd(int'(m_bin));
                    m_active   = 1'b0;
                end
            end
            if (!rst_i && conv_en_o) begin
                chk(!m_active && !prev_en, "conv_en_single",
                    $sformatf("got strobe with converter busy %0d prev strobe %0d, required 0 0",
                              m_active, prev_en));
                en_count++;
                en_cyc = cyc;
                if (!stall) begin
                    m_active = 1'b1;
                    m_rem    = lat;
                    m_bin    = conv_bin_o;
                end
            end
            prev_en = conv_en_o;
        end
    end

    task automatic do_reset(input int n);
        @(negedge clk_i);
        rst_i = 1'b1;
        req_i = '0;
        repeat (n) @(negedge clk_i);
        chk(ack_o == '0 && res_valid_o == '0 && bcd_out_o == '0 && !err_o && err_ch_o == 3'd0 &&
            !busy_o && !conv_en_o && conv_bin_o == 12'd0, "reset_values",
            $sformatf("got ack %b rv %b bcd %h err %b ch %0d busy %b en %b bin %h, required all zero",
                      ack_o, res_valid_o, bcd_out_o, err_o, err_ch_o, busy_o, conv_en_o, conv_bin_o));
        exp_q.delete();
        rr_ptr = 0;
        for (int k = 0; k < NUM_CH; k++) exp_bcd[k] = '0;
        rst_i = 1'b0;
        d0    = cyc;
    endtask

    task automatic wait_ack(input int g);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!ack_o[g] && n < BUDGET);
        chk(ack_o[g], "ack_wait",
            $sformatf("got ack %b after %0d cycles, required bit %0d set", ack_o, n, g));
        last_ack_cyc = cyc;
    endtask

    task automatic wait_q_empty();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < BUDGET) begin
            @(negedge clk_i);
            n++;
        end
        chk(exp_q.size() == 0, "response_wait",
            $sformatf("got %0d pending events, required 0", exp_q.size()));
    endtask

    task automatic run_seq(input logic [NUM_CH-1:0] mask, input int n, input bit drop_each);
        logic [NUM_CH-1:0] pend;
        int order[$];
        int g;
        pend = mask;
        for (int t = 0; t < n; t++) begin
            g = rr_pick(pend);
            order.push_back(g);
            push_exp(EV_ACK, g, 16'h0);
            push_exp(EV_RES, g, ref_bcd(int'(vals[g])));
            rr_ptr = (g + 1) % NUM_CH;
            if (drop_each) pend[g] = 1'b0;
        end
        for (int k = 0; k < NUM_CH; k++) bin_in_i[k*12 +: 12] = vals[k];
        req_i = mask;
        foreach (order[i]) begin
            wait_ack(order[i]);
            if (drop_each) req_i[order[i]] = 1'b0;
        end
        req_i = '0;
        wait_q_empty();
    endtask

    initial begin
        logic [NUM_CH-1:0] mask;
        for (int k = 0; k < NUM_CH; k++) vals[k] = '0;

        // Drain after reset, then a single full-scale conversion.
        do_reset(3);
        vals[0] = 12'd4095;
        run_seq(4'b0001, 1, 1'b1);
        chk(last_ack_cyc == d0 + TIMEOUT + 2, "drain_then_ack",
            $sformatf("got ack at cycle %0d, required %0d", last_ack_cyc, d0 + TIMEOUT + 2));
        chk(en_count == 1, "single_conv_en",
            $sformatf("got %0d strobes, required 1", en_count));

        // All four requesting together from a fresh pointer.
        do_reset(2);
        vals[0] = 12'd0;
        vals[1] = 12'd9;
        vals[2] = 12'd999;
        vals[3] = 12'd1234;
        run_seq(4'b1111, 4, 1'b1);

        // Two channels holding their requests.
        vals[0] = 12'($urandom_range(0, 4095));
        vals[2] = 12'($urandom_range(0, 4095));
        run_seq(4'b0101, 4, 1'b0);

        // Hung converter on channel 1.
        stall   = 1'b1;
        vals[1] = 12'($urandom_range(0, 4095));
        push_exp(EV_ACK, 1, 16'h0);
        push_exp(EV_ERR, 1, 16'h0);
        rr_ptr = 2;
        bin_in_i[12 +: 12] = vals[1];
        req_i = 4'b0010;
        wait_ack(1);
        req_i = '0;
        wait_q_empty();
        chk(err_cyc - en_cyc == TIMEOUT + 1, "timeout_cycle",
            $sformatf("got err %0d cycles after strobe, required %0d", err_cyc - en_cyc, TIMEOUT + 1));
        repeat (10) @(negedge clk_i);
        chk(err_ch_o == 3'd1 && busy_o, "err_ch_held_drain",
            $sformatf("got err_ch %0d busy %b, required 1 1", err_ch_o, busy_o));
        stall   = 1'b0;
        vals[1] = 12'($urandom_range(0, 4095));
        run_seq(4'b0010, 1, 1'b1);

        // Reset mid-conversion; the late answer lands in the drain.
        vals[2] = 12'($urandom_range(1, 4095));
        push_exp(EV_ACK, 2, 16'h0);
        rr_ptr = 3;
        bin_in_i[24 +: 12] = vals[2];
        req_i = 4'b0100;
        wait_ack(2);
        req_i = '0;
        repeat (20) @(negedge clk_i);
        do_reset(1);
        repeat (80) @(negedge clk_i);
        chk(!busy_o, "drain_exit_on_rdy",
            $sformatf("got busy %b, required 0", busy_o));
        chk(bcd_out_o == '0 && !m_active, "late_rdy_discarded",
            $sformatf("got bcd %h converter busy %0d, required 0 0", bcd_out_o, m_active));
        vals[3] = 12'($urandom_range(0, 4095));
        run_seq(4'b1000, 1, 1'b1);

        // Spurious conv_rdy while idle.
        spur = 1'b1;
        repeat (6) @(negedge clk_i);
        chk(!busy_o && res_valid_o == '0 && bcd_out_o == pack_bcd(), "spurious_rdy_idle",
            $sformatf("got busy %b rv %b bcd %h, required 0 0 %h", busy_o, res_valid_o, bcd_out_o, pack_bcd()));

        // conv_rdy on the last allowed WAIT cycle is still a success.
        lat     = TIMEOUT;
        vals[1] = 12'($urandom_range(0, 4095));
        run_seq(4'b0010, 1, 1'b1);
        lat     = NOM_LAT;

        // Random masks, operands and converter latencies.
        repeat (6) begin
            mask = NUM_CH'($urandom_range(1, 15));
            for (int k = 0; k < NUM_CH; k++) vals[k] = 12'($urandom_range(0, 4095));
            lat = $urandom_range(1, TIMEOUT - 1);
            run_seq(mask, $countones(mask), 1'b1);
        end

        chk(exp_q.size() == 0, "scoreboard_empty",
            $sformatf("got %0d left, required 0", exp_q.size()));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish by time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
